// File: rtl/lut_eval_pkg.sv
// Shared types and helpers for the LUT evaluator.
// Holds the sweep FSM state enum, table width helper and input limit.
package lut_eval_pkg;

  localparam int MAX_N_IN = 6;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } sweep_state_t;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lut_eval_core.sv
// Combinational truth-table lookup shared by eval and sweep.
// Ports: tt (table), sel (index), y (selected table bit).
module lut_eval_core
  import lut_eval_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int TT_W = tt_width(N_IN)
) (
  input  logic [TT_W-1:0] tt,
  input  logic [N_IN-1:0] sel,
  output logic            y
);

  assign y = tt[sel];

endmodule

// File: rtl/lut_eval_seq.sv
// Clocked N_IN-input LUT evaluator with valid/ready eval and self-sweep.
// Ports: cfg_* table load, in_*/out_* eval stream, sweep_* self-check.
module lut_eval_seq
  import lut_eval_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int CNT_W = 16,
  localparam int TT_W  = tt_width(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [TT_W-1:0]  cfg_tt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [TT_W-1:0]  sweep_sig,
  output logic             sweep_match,
  output logic [CNT_W-1:0] eval_count
);

  localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(TT_W - 1);

  sweep_state_t    state_q;
  sweep_state_t    state_d;
  logic [N_IN:0]   idx_q;
  logic [TT_W-1:0] tt_reg;
  logic [N_IN-1:0] lut_sel;
  logic            lut_y;
  logic            cfg_fire;
  logic            in_fire;
  logic            sweep_go;
  logic            in_sweep;

  assign in_sweep   = (state_q == SWEEP);
  assign cfg_ready  = (state_q == IDLE) && !out_valid;
  assign in_ready   = (state_q == IDLE) && (!out_valid || out_ready);
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign in_fire    = in_valid && in_ready;
  // a load in the same cycle wins; the sweep request is dropped
  assign sweep_go   = sweep_start && cfg_ready && !cfg_valid;
  assign sweep_busy = (state_q != IDLE);
  assign sweep_done = (state_q == DONE);

  // sweep drives the real lookup path so it checks the eval mux
  assign lut_sel = in_sweep ? idx_q[N_IN-1:0] : in_vec;

  lut_eval_core #(
    .N_IN (N_IN),
    .TT_W (TT_W)
  ) u_core (
    .tt  (tt_reg),
    .sel (lut_sel),
    .y   (lut_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sweep_go) state_d = SWEEP;
      SWEEP:   if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sweep_sig   <= '0;
      sweep_match <= 1'b0;
    end else begin
      state_q <= state_d;
      if (sweep_go) begin
        idx_q     <= '0;
        sweep_sig <= '0;
      end else if (in_sweep) begin
        sweep_sig[idx_q[N_IN-1:0]] <= lut_y;
        idx_q <= idx_q + 1'b1;
      end
      if (state_q == DONE)
        sweep_match <= (sweep_sig == tt_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_reg     <= '0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      eval_count <= '0;
    end else begin
      if (cfg_fire)
        tt_reg <= cfg_tt;
      if (in_fire) begin
        out_valid <= 1'b1;
        out_bit   <= lut_y;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (cfg_fire)
        eval_count <= '0;
      else if (in_fire && (eval_count != '1))
        eval_count <= eval_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lut_eval_seq.sv
// Directed testbench for lut_eval_seq (N_IN=4 and N_IN=3 instances).
// Each task drives one scenario and checks results inline.
module tb_lut_eval_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        cfg_valid, cfg_ready;
  logic [15:0] cfg_tt;
  logic        in_valid, in_ready;
  logic [3:0]  in_vec;
  logic        out_valid, out_ready, out_bit;
  logic        sweep_start, sweep_busy, sweep_done;
  logic [15:0] sweep_sig;
  logic        sweep_match;
  logic [15:0] eval_count;

  logic        cfg_valid3, cfg_ready3;
  logic [7:0]  cfg_tt3;
  logic        in_valid3, in_ready3;
  logic [2:0]  in_vec3;
  logic        out_valid3, out_ready3, out_bit3;
  logic        sweep_start3, sweep_busy3, sweep_done3;
  logic [7:0]  sweep_sig3;
  logic        sweep_match3;
  logic [2:0]  eval_count3;

  lut_eval_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_tt      (cfg_tt),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bit     (out_bit),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_sig   (sweep_sig),
    .sweep_match (sweep_match),
    .eval_count  (eval_count)
  );

  lut_eval_seq #(
    .N_IN  (3),
    .CNT_W (3)
  ) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid3),
    .cfg_ready   (cfg_ready3),
    .cfg_tt      (cfg_tt3),
    .in_valid    (in_valid3),
    .in_ready    (in_ready3),
    .in_vec      (in_vec3),
    .out_valid   (out_valid3),
    .out_ready   (out_ready3),
    .out_bit     (out_bit3),
    .sweep_start (sweep_start3),
    .sweep_busy  (sweep_busy3),
    .sweep_done  (sweep_done3),
    .sweep_sig   (sweep_sig3),
    .sweep_match (sweep_match3),
    .eval_count  (eval_count3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b1; cfg_tt = 16'h0068;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    sweep_start = 1'b0;
    cfg_valid3 = 1'b0; cfg_tt3 = '0; in_valid3 = 1'b0;
    in_vec3 = '0; out_ready3 = 1'b0; sweep_start3 = 1'b0;
    step(); step();
    cfg_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({out_valid, out_bit, sweep_busy, sweep_done, sweep_match} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {out_valid, out_bit, sweep_busy, sweep_done, sweep_match});
    end
    checks++;
    if (sweep_sig !== 16'h0) begin
      errors++;
      $display("FAIL reset_sig got %h want 0000", sweep_sig);
    end
    checks++;
    if (eval_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", eval_count);
    end
    checks++;
    if ({cfg_ready, in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready got %b want 11", {cfg_ready, in_ready});
    end
    // table must still be zero: index 3 would be 1 under 0x0068
    in_valid = 1'b1; in_vec = 4'd3;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if ({out_valid, out_bit} !== 2'b10) begin
      errors++;
      $display("FAIL reset_tt got %b want 10", {out_valid, out_bit});
    end
    step();
  endtask

  task automatic load(input logic [15:0] tt);
    cfg_valid = 1'b1; cfg_tt = tt;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready got %b want 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    checks++;
    if (eval_count !== 16'd0) begin
      errors++;
      $display("FAIL load_count got %0d want 0", eval_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vecs [5] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic       exp  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    load(16'h0068);
    out_ready = 1'b1;
    in_valid = 1'b1; in_vec = vecs[0];
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, out_bit} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL b2b[%0d] got %b want %b", i,
                 {out_valid, out_bit}, {1'b1, exp[i]});
      end
      if (i < 4) in_vec = vecs[i+1];
      else in_valid = 1'b0;
      step();
    end
    checks++;
    if ({out_valid, eval_count} !== {1'b0, 16'd5}) begin
      errors++;
      $display("FAIL b2b_end got v=%b n=%0d want v=0 n=5",
               out_valid, eval_count);
    end
  endtask

  task automatic test_backpressure();
    load(16'h0068);
    out_ready = 1'b0;
    in_valid = 1'b1; in_vec = 4'd3;
    step();
    in_vec = 4'd4;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({in_ready, out_valid, out_bit} !== 3'b011) begin
        errors++;
        $display("FAIL bp_hold[%0d] got %b want 011", k,
                 {in_ready, out_valid, out_bit});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %b want 1", in_ready);
    end
    step();
    in_vec = 4'd5;
    checks++;
    if ({out_valid, out_bit} !== 2'b10) begin
      errors++;
      $display("FAIL bp_r4 got %b want 10", {out_valid, out_bit});
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_bit} !== 2'b11) begin
      errors++;
      $display("FAIL bp_r5 got %b want 11", {out_valid, out_bit});
    end
    step();
    checks++;
    if ({out_valid, eval_count} !== {1'b0, 16'd3}) begin
      errors++;
      $display("FAIL bp_end got v=%b n=%0d want v=0 n=3",
               out_valid, eval_count);
    end
  endtask

  task automatic test_sweep();
    int n = 0;
    int dn = 0;
    int bad = 0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    in_valid = 1'b1; in_vec = 4'd6; out_ready = 1'b1;
    while (sweep_busy && n < 40) begin
      n++;
      if (sweep_done) dn++;
      if (in_ready || out_valid) bad++;
      step();
    end
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL sweep_len got %0d want 17", n);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL sweep_done_cnt got %0d want 1", dn);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL sweep_stall got %0d want 0", bad);
    end
    checks++;
    if ({sweep_sig, sweep_match} !== {16'h0068, 1'b1}) begin
      errors++;
      $display("FAIL sweep_sig got %h m=%b want 0068 m=1",
               sweep_sig, sweep_match);
    end
    checks++;
    if ({in_ready, eval_count} !== {1'b1, 16'd3}) begin
      errors++;
      $display("FAIL sweep_after got r=%b n=%0d want r=1 n=3",
               in_ready, eval_count);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_bit, eval_count} !== {2'b11, 16'd4}) begin
      errors++;
      $display("FAIL sweep_stalled_in got %b n=%0d want 11 n=4",
               {out_valid, out_bit}, eval_count);
    end
    step();
  endtask

  task automatic test_cfg_priority();
    int n = 0;
    cfg_valid = 1'b1; cfg_tt = 16'hFFFF; sweep_start = 1'b1;
    step();
    cfg_valid = 1'b0; sweep_start = 1'b0;
    checks++;
    if ({sweep_busy, eval_count} !== {1'b0, 16'd0}) begin
      errors++;
      $display("FAIL prio got b=%b n=%0d want b=0 n=0",
               sweep_busy, eval_count);
    end
    step();
    checks++;
    if (sweep_busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_queued got %b want 0", sweep_busy);
    end
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    while (sweep_busy && n < 40) begin
      n++;
      step();
    end
    checks++;
    if ({sweep_sig, sweep_match} !== {16'hFFFF, 1'b1} || n !== 17) begin
      errors++;
      $display("FAIL prio_sweep got %h m=%b len=%0d want FFFF m=1 len=17",
               sweep_sig, sweep_match, n);
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    load(16'h0068);
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    repeat (7) step();
    checks++;
    if ({sweep_busy, sweep_sig} !== {1'b1, 16'h0068}) begin
      errors++;
      $display("FAIL mid_partial got b=%b %h want b=1 0068",
               sweep_busy, sweep_sig);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sweep_busy, sweep_done, sweep_sig} !== 18'h0) begin
      errors++;
      $display("FAIL mid_abort got b=%b d=%b %h want 0 0 0000",
               sweep_busy, sweep_done, sweep_sig);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sweep_done || sweep_busy) dn++;
      step();
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL mid_resume got %0d want 0", dn);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_vec = 4'd3;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL txn_pending got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, eval_count} !== {1'b0, 16'd0}) begin
      errors++;
      $display("FAIL txn_abort got v=%b n=%0d want v=0 n=0",
               out_valid, eval_count);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL txn_resume got %b want 0", out_valid);
    end
  endtask

  task automatic test_n3();
    int n = 0;
    cfg_valid3 = 1'b1; cfg_tt3 = 8'hE8;
    step();
    cfg_valid3 = 1'b0;
    out_ready3 = 1'b1;
    in_valid3 = 1'b1; in_vec3 = 3'd3;
    step();
    in_vec3 = 3'd4;
    checks++;
    if ({out_valid3, out_bit3} !== 2'b11) begin
      errors++;
      $display("FAIL n3_eval3 got %b want 11", {out_valid3, out_bit3});
    end
    step();
    in_valid3 = 1'b0;
    checks++;
    if ({out_valid3, out_bit3} !== 2'b10) begin
      errors++;
      $display("FAIL n3_eval4 got %b want 10", {out_valid3, out_bit3});
    end
    step();
    sweep_start3 = 1'b1;
    step();
    sweep_start3 = 1'b0;
    while (sweep_busy3 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if ({sweep_sig3, sweep_match3} !== {8'hE8, 1'b1} || n !== 9) begin
      errors++;
      $display("FAIL n3_sweep got %h m=%b len=%0d want E8 m=1 len=9",
               sweep_sig3, sweep_match3, n);
    end
    in_valid3 = 1'b1; in_vec3 = 3'd7;
    repeat (10) step();
    in_valid3 = 1'b0;
    step();
    checks++;
    if (eval_count3 !== 3'd7) begin
      errors++;
      $display("FAIL n3_saturate got %0d want 7", eval_count3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_sweep();
    test_cfg_priority();
    test_reset_mid();
    test_n3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_eval_seq.md
Name: lut_eval_seq

Overview:
- Parametrised, clocked successor to the fixed 4-input Cello NOR/NOT netlists.
- Holds a runtime-loadable truth table (for example 0x0068) for an N_IN-input, 1-output function.
- Evaluates input vectors through a valid/ready pipeline.
- Provides a sweep mode that walks every input combination and rebuilds the truth-table signature, so the lookup path checks itself.
- Sits between the design-enumeration harness and the golden-model comparator.

Parameters:
- N_IN, 4, number of logic inputs (1..6).
- TT_W, 2**N_IN, truth-table width. Derived; not overridable.
- CNT_W, 16, width of the saturating evaluation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  truth-table load request.
- cfg_ready  out  1  load accepted this cycle when high with cfg_valid.
- cfg_tt  in  TT_W  truth table; bit i is the output for input index i.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept an input vector.
- in_vec  in  N_IN  input vector as an unsigned index; in_vec[N_IN-1] is the first-listed Cello input.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_bit  out  1  function value.
- sweep_start  in  1  single-cycle request to run a sweep.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at sweep completion.
- sweep_sig  out  TT_W  rebuilt signature from the last sweep.
- sweep_match  out  1  sweep_sig == tt_reg, sampled at sweep_done.
- eval_count  out  CNT_W  accepted evaluations since reset or last load; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n low). All of the following are cleared:
  - tt_reg=0, out_valid=0, out_bit=0
  - sweep_busy=0, sweep_done=0, sweep_sig=0, sweep_match=0
  - eval_count=0, FSM=IDLE, idx=0
- Reset asserted mid-sweep or mid-transaction aborts it immediately; nothing resumes after release.
- Config:
  - cfg_ready = (FSM==IDLE) && !out_valid.
  - On cfg_valid && cfg_ready: tt_reg <= cfg_tt and eval_count <= 0.
  - The new table is used from the next cycle.
- Evaluation:
  - in_ready = (FSM==IDLE) && (!out_valid || out_ready).
  - On in_valid && in_ready: out_bit <= tt_reg[in_vec], out_valid <= 1, eval_count increments (saturating).
  - Latency is 1 cycle, and one result is accepted per cycle with back-to-back transfers.
  - out_valid clears on out_ready when no new input is accepted in the same cycle.
  - While out_valid && !out_ready, out_bit is held stable.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start when cfg_ready is high (no pending output, no load this cycle). In the same cycle: idx <= 0, sweep_sig <= 0.
  - sweep_start is ignored in any other state or condition; it is not queued.
  - Config has priority: if cfg_valid and sweep_start are both high in IDLE, the load is taken and the sweep request is dropped.
  - SWEEP: each cycle, sweep_sig[idx] <= lookup(tt_reg, idx), using the same lookup function as evaluation.
  - In SWEEP, idx increments; at idx==TT_W-1 the FSM goes to DONE. The sweep is exactly TT_W cycles with no wrap.
  - DONE: sweep_done=1 for one cycle and sweep_match registered. Next state is IDLE.
  - sweep_busy is high in SWEEP and DONE.
  - The evaluation counter is not affected by sweeps.
- Widths:
  - idx is N_IN+1 bits, so the terminal compare cannot overflow.
  - eval_count holds at 2**CNT_W-1.
- Simultaneous events:
  - out_ready together with in_valid on a full output register gives replace-in-place with no bubble.
  - in_valid during a sweep is stalled (in_ready low), not dropped.

Decomposition:
- Shared package lut_eval_pkg holds:
  - sweep FSM state enum {IDLE, SWEEP, DONE}
  - function tt_width(n)
  - constant MAX_N_IN = 6
- Sub-module lut_eval_core: purely combinational mux, N_IN/TT_W parametrised, instantiated once.
- The eval and sweep paths share lut_eval_core through an index mux selected by FSM==SWEEP, so the sweep exercises the real datapath.

Test Plan:
- Reset with cfg_tt=0x0068 loaded → all outputs are 0 after rst_n rises; eval_count=0.
- Load 0x0068, send in_vec 3,4,5,6,7 back-to-back with out_ready=1 → out_bit 1,0,1,1,0 on consecutive cycles; eval_count=5.
- Backpressure: out_ready=0 for 3 cycles after the first result → in_ready=0, out_bit is held; on release, remaining results arrive in order with none lost.
- Sweep with 0x0068:
  - sweep_busy high for 17 cycles (16 SWEEP + DONE)
  - sweep_sig=0x0068, sweep_match=1, one sweep_done pulse
  - in_valid asserted during the sweep stalls
- sweep_start and cfg_valid=0xFFFF in the same IDLE cycle → load taken, no sweep, eval_count=0; a later sweep gives sweep_sig=0xFFFF.
- rst_n low during SWEEP at idx=7 → FSM=IDLE and sweep_sig=0 immediately, with no sweep_done. Repeat with N_IN=3, table 0xE8 → sweep_sig=0xE8 after 8 cycles.
